puart_rx_fifo: RTL
==================

# puart_rx_fifo

Parametrised UART receiver for the FPGA verification platform. It runs on a runtime-programmable baud divisor and supports a configurable data width, optional parity, and one or two stop bits. Received words and their per-word error flags are buffered in an internal FIFO drained through a valid/ready interface. It sits between the board RX pin and the host-loader or debug logic, and replaces the fixed 8N1, single-register receiver.

## Interface
- `DATA_W`, 8: data bits per frame, legal range 5..9.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `rx_i` in 1: asynchronous serial input; idles high.
- `clks_per_bit_i` in DIV_W: clk_i cycles per bit; legal values ≥4.
- `parity_en_i` in 1: expect a parity bit after the data bits.
- `parity_odd_i` in 1: 1 selects odd parity, 0 selects even.
- `two_stop_i` in 1: expect two stop bits.
- `rx_data_o` out DATA_W: head-of-FIFO word, LSB received first.
- `rx_frame_err_o` out 1: head word had a low stop bit.
- `rx_parity_err_o` out 1: head word failed the parity check.
- `rx_valid_o` out 1: FIFO not empty.
- `rx_ready_i` in 1: consumer accepts the head word.
- `overrun_o` out 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- `busy_o` out 1: FSM is not in IDLE.
- `fifo_level_o` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input sync:** `rx_i` passes through a 2-flop synchroniser; both flops reset to 1. The FSM sees only the synchronised value `rxs`.
- **Config latch:** `clks_per_bit_i`, `parity_en_i`, `parity_odd_i` and `two_stop_i` are latched on the IDLE→START transition. Changes mid-frame have no effect on the current frame.
- **IDLE:**
  - Counter and bit index are cleared.
  - `rxs`=0 → START.
- **START:**
  - Count to `(cpb-1)>>1`, then re-sample.
  - `rxs`=0 → DATA with the counter cleared.
  - `rxs`=1 → IDLE (glitch rejected, nothing pushed).
- **DATA:**
  - Every `cpb` cycles, sample into `shift[idx]`, with idx counting 0..DATA_W-1.
  - After the last bit → PARITY if parity is enabled, else STOP.
- **PARITY:**
  - Sample after `cpb` cycles.
  - Error = (XOR of data bits ^ sampled bit) != `parity_odd`.
  - → STOP.
- **STOP:**
  - Sample after `cpb` cycles; `rxs`=0 sets the frame error.
  - If `two_stop` and this is the first stop bit, repeat STOP once; either stop bit low sets the frame error.
  - On the final stop sample, push {parity_err, frame_err, data}.
  - Exit: no frame error → IDLE; frame error → WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then → IDLE. This prevents a break or held-low line from retriggering reception.
- **FIFO:**
  - Circular buffer, DATA_W+2 bits wide, with read/write pointers one bit wider than the address.
  - Push when the FIFO is full and no pop is occurring in the same cycle → word dropped and `overrun_o` pulses.
  - Push and pop in the same cycle while full → both accepted; level unchanged, no overrun.
  - Push and pop in the same cycle while empty → not possible, since valid is registered from the level.
- **Counter arithmetic:** the counter is DIV_W bits wide and `cpb-1` is computed in DIV_W bits; the counter never wraps for legal divisors.
- **Reset mid-frame:**
  - FSM → IDLE; FIFO emptied; synchroniser flops → 1.
  - The partial word is discarded.
  - If the line is still low after reset, the next falling condition starts a fresh frame.

## Timing
- **Reset values:**
  - `rx_data_o`=0, both error flags 0.
  - `rx_valid_o`=0, `overrun_o`=0, `busy_o`=0, `fifo_level_o`=0.
- **Start detect:** 2 cycles of synchroniser latency, then 1 cycle to leave IDLE.
- **Push:** occurs in the cycle of the final stop-bit sample.
- **Push to output:** `rx_valid_o` and the data are visible the next cycle; `fifo_level_o` updates the same edge.
- **Pop:** a handshake at edge T presents the next word, or deasserts valid, at T+1.
- **Frame length:** for an 8N1 frame with cpb=N, push occurs ≈9.5·N+3 cycles after the `rx_i` falling edge.
- **Output stability:** `rx_data_o` and the flags are stable while valid is high and ready is low.

## Configuration
- **`PUART_RX_FIFO_PARITY_EN` defined:**
  - `parity_en_i` and `parity_odd_i` are honoured.
  - The PARITY state and the parity error flag are present.
- **`PUART_RX_FIFO_PARITY_EN` undefined:**
  - The parity ports are ignored and the PARITY state is not generated.
  - `rx_parity_err_o` is tied to 0 and the FIFO width is DATA_W+1.
  - A parity bit on the line is interpreted as the first stop bit.

## Test plan
- **8N1 basic:** cpb=16, 8N1, send 0xA5 with `rx_ready_i`=1 → one valid beat, data 0xA5, both error flags 0.
- **Parity error:** with the macro defined, even parity, send 0x03 with parity bit=1 → data 0x03, `rx_parity_err_o`=1. The same frame with parity bit 0 → flag 0.
- **Framing error:** send 0x55 with the stop bit low, then hold the line low for 3·cpb → one word with `rx_frame_err_o`=1. No further word until the line goes high and a new start bit arrives.
- **Glitch rejection:** cpb=16, pulse `rx_i` low for 4 cycles → no push, `busy_o` returns to 0 within 12 cycles.
- **Overrun:** FIFO_DEPTH=8, `rx_ready_i`=0, send 0x01..0x09 →
  - `fifo_level_o`=8 and `overrun_o` pulses exactly once;
  - after raising ready, pops return 0x01..0x08 in order.
- **Reset mid-frame:** assert `rst_i` during bit 4 of 0xF0 → all outputs at reset values. A following 0x3C is received correctly with 2 stop bits and cpb=5.

Source files
------------

// File: rtl/puart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : puart_rx_fifo
// Brief    : UART receiver with a runtime baud divisor, configurable data
//            width, one/two stop bits and a word+flags FIFO drained through
//            valid/ready. Define PUART_RX_FIFO_PARITY_EN to enable parity.
// Revision : 1.0 - initial release
// ============================================================================
module puart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    input  logic [DIV_W-1:0]              clks_per_bit_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          two_stop_i,
    output logic [DATA_W-1:0]             rx_data_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_parity_err_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          overrun_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_IW = $clog2(DATA_W);
`ifdef PUART_RX_FIFO_PARITY_EN
    localparam int c_FW = DATA_W + 2;
`else
    localparam int c_FW = DATA_W + 1;
`endif
    localparam logic [DIV_W-1:0] c_ONE      = DIV_W'(1);
    localparam logic [c_IW-1:0]  c_IDX_ONE  = c_IW'(1);
    localparam logic [c_IW-1:0]  c_LAST     = c_IW'(DATA_W - 1);
    localparam logic [c_AW:0]    c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
`ifdef PUART_RX_FIFO_PARITY_EN
    localparam logic [2:0] c_PARITY    = 3'd3;
`endif
    localparam logic [2:0] c_STOP      = 3'd4;
    localparam logic [2:0] c_WAIT_HIGH = 3'd5;

    logic                r_sync1, r_sync2, w_rxs;
    logic [2:0]          r_state, w_state_nxt;
    logic [DIV_W-1:0]    r_cnt, r_cpb, w_cpb_m1;
    logic [c_IW-1:0]     r_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_ferr, r_stop2, r_two_stop;
    logic                w_bit_tick, w_half_tick, w_last_stop, w_ferr_nxt, w_push;
`ifdef PUART_RX_FIFO_PARITY_EN
    logic                r_par_en, r_par_odd, r_perr;
`else
    logic                w_unused_parity;
    assign w_unused_parity = parity_en_i ^ parity_odd_i;
`endif

    // Both stages idle high so leaving reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rxs = r_sync2;

    assign w_cpb_m1    = r_cpb - c_ONE;
    assign w_bit_tick  = (r_cnt == w_cpb_m1);
    assign w_half_tick = (r_cnt == (w_cpb_m1 >> 1));
    assign w_last_stop = !r_two_stop || r_stop2;
    assign w_ferr_nxt  = r_ferr | ~w_rxs;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:      if (!w_rxs) w_state_nxt = c_START;
            c_START:     if (w_half_tick) w_state_nxt = w_rxs ? c_IDLE : c_DATA;
            c_DATA: begin
                if (w_bit_tick && (r_idx == c_LAST)) begin
`ifdef PUART_RX_FIFO_PARITY_EN
                    w_state_nxt = r_par_en ? c_PARITY : c_STOP;
`else
                    w_state_nxt = c_STOP;
`endif
                end
            end
`ifdef PUART_RX_FIFO_PARITY_EN
            c_PARITY:    if (w_bit_tick) w_state_nxt = c_STOP;
`endif
            c_STOP:      if (w_bit_tick && w_last_stop) w_state_nxt = w_ferr_nxt ? c_WAIT_HIGH : c_IDLE;
            c_WAIT_HIGH: if (w_rxs) w_state_nxt = c_IDLE;
            default:     w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state != c_IDLE);
        w_push = (r_state == c_STOP) && w_bit_tick && w_last_stop;
    end

    // Frame configuration is captured on the IDLE->START edge only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_stop2    <= 1'b0;
            r_cpb      <= '0;
            r_two_stop <= 1'b0;
`ifdef PUART_RX_FIFO_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_ferr  <= 1'b0;
                    r_stop2 <= 1'b0;
`ifdef PUART_RX_FIFO_PARITY_EN
                    r_perr  <= 1'b0;
`endif
                    if (!w_rxs) begin
                        r_cpb      <= clks_per_bit_i;
                        r_two_stop <= two_stop_i;
`ifdef PUART_RX_FIFO_PARITY_EN
                        r_par_en   <= parity_en_i;
                        r_par_odd  <= parity_odd_i;
`endif
                    end
                end
                c_START: r_cnt <= w_half_tick ? '0 : r_cnt + c_ONE;
                c_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        r_idx          <= (r_idx == c_LAST) ? '0 : r_idx + c_IDX_ONE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
`ifdef PUART_RX_FIFO_PARITY_EN
                c_PARITY: begin
                    if (w_bit_tick) begin
                        r_cnt  <= '0;
                        r_perr <= ((^r_shift) ^ w_rxs) != r_par_odd;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
`endif
                c_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt  <= '0;
                        r_ferr <= w_ferr_nxt;
                        if (!w_last_stop) r_stop2 <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    logic [c_FW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr_ptr, r_rd_ptr, w_level;
    logic [c_FW-1:0] w_word, w_head;
    logic            w_full, w_valid, w_pop, w_wr_en, r_overrun;

`ifdef PUART_RX_FIFO_PARITY_EN
    assign w_word = {r_perr, w_ferr_nxt, r_shift};
`else
    assign w_word = {w_ferr_nxt, r_shift};
`endif

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == c_DEPTH);
    assign w_valid = (w_level != '0);
    assign w_pop   = w_valid & rx_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= w_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overrun <= w_push & w_full & ~w_pop;
        end
    end

    assign w_head         = r_mem[r_rd_ptr[c_AW-1:0]];
    assign rx_valid_o     = w_valid;
    assign rx_data_o      = w_valid ? w_head[DATA_W-1:0] : '0;
    assign rx_frame_err_o = w_valid & w_head[DATA_W];
`ifdef PUART_RX_FIFO_PARITY_EN
    assign rx_parity_err_o = w_valid & w_head[DATA_W+1];
`else
    assign rx_parity_err_o = 1'b0;
`endif
    assign overrun_o      = r_overrun;
    assign fifo_level_o   = w_level;

endmodule
`default_nettype wire
